// File: rtl/fetch_stage.sv
// fetch_stage: front end of the RV32IM core.
// Holds the fetch PC, issues one instruction-memory request at a time, and
// loads the fetch/decode pipeline register that decode consumes. A response
// that lands while decode is stalled is parked in hold_buf; a response that a
// flush has made stale is discarded in S_DROP.
module fetch_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] PC_RESET = 32'h0000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_ready_i,
  input  logic [XLEN-1:0] instr_i,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic            instr_valid_o
);

  localparam logic [XLEN-1:0] NOP = XLEN'(32'h0000_0013);

  // S_REQ  : request for fetch_addr outstanding, response goes to decode
  // S_DROP : request outstanding but made stale by a flush; pending_pc is next
  // S_HOLD : response parked in hold_buf while decode is stalled, no request
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_DROP = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            req_en_q;
  logic [XLEN-1:0] fetch_addr_q, fetch_addr_d;
  logic [XLEN-1:0] pending_pc_q, pending_pc_d;
  logic [XLEN-1:0] hold_buf_q, hold_buf_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  logic            handshake;
  logic [XLEN-1:0] redirect_pc;
  logic [XLEN-1:0] fetch_addr_inc;
  logic [XLEN-1:0] hold_pc;

  // req_en_q keeps the request low for the first cycle after reset so the
  // first request appears one cycle after rst_i deasserts.
  assign instr_req_o   = req_en_q && (state_q != S_HOLD);
  assign instr_addr_o  = fetch_addr_q;
  assign instr_o       = instr_q;
  assign pc_o          = pc_q;
  assign instr_valid_o = valid_q;

  // A strobe only counts while our request is on the bus.
  assign handshake      = instr_req_o && instr_ready_i;
  // Redirect targets are word aligned; the two low bits are forced to zero.
  assign redirect_pc    = redirect_pc_i & ~XLEN'(3);
  // Wraps modulo 2^XLEN with no fault.
  assign fetch_addr_inc = fetch_addr_q + XLEN'(4);
  // fetch_addr already advanced past the parked instruction.
  assign hold_pc        = fetch_addr_q - XLEN'(4);

  // Next-state and datapath decisions for the fetch FSM.
  always_comb begin
    // NOTE: every *_d gets its hold value first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    pending_pc_d = pending_pc_q;
    hold_buf_d   = hold_buf_q;
    instr_d      = instr_q;
    pc_d         = pc_q;
    valid_d      = valid_q;

    case (state_q)
      S_REQ: begin
        if (flush_i) begin
          valid_d = 1'b0;
          if (handshake || !req_en_q) begin
            // Response (if any) is wrong-path; restart at the target now.
            fetch_addr_d = redirect_pc;
          end else begin
            // Our request is still in flight; wait for it, then redirect.
            pending_pc_d = redirect_pc;
            state_d      = S_DROP;
          end
        end else if (handshake) begin
          fetch_addr_d = fetch_addr_inc;
          if (!stall_i) begin
            instr_d = instr_i;
            pc_d    = fetch_addr_q;
            valid_d = 1'b1;
          end else begin
            hold_buf_d = instr_i;
            state_d    = S_HOLD;
          end
        end else if (!stall_i) begin
          valid_d = 1'b0;
        end
      end

      S_DROP: begin
        valid_d = 1'b0;
        if (handshake) begin
          fetch_addr_d = flush_i ? redirect_pc : pending_pc_q;
          state_d      = S_REQ;
        end else if (flush_i) begin
          pending_pc_d = redirect_pc;
        end
      end

      S_HOLD: begin
        if (flush_i) begin
          valid_d      = 1'b0;
          fetch_addr_d = redirect_pc;
          state_d      = S_REQ;
        end else if (!stall_i) begin
          instr_d = hold_buf_q;
          pc_d    = hold_pc;
          valid_d = 1'b1;
          state_d = S_REQ;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      // NOTE: pending_pc and hold_buf are reset too; they are plain flops, not
      // a memory array, so this costs nothing and keeps reset deterministic.
      state_q      <= S_REQ;
      req_en_q     <= 1'b0;
      fetch_addr_q <= PC_RESET;
      pending_pc_q <= PC_RESET;
      hold_buf_q   <= NOP;
      instr_q      <= NOP;
      pc_q         <= PC_RESET;
      valid_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q      <= state_d;
      req_en_q     <= 1'b1;
      fetch_addr_q <= fetch_addr_d;
      pending_pc_q <= pending_pc_d;
      hold_buf_q   <= hold_buf_d;
      instr_q      <= instr_d;
      pc_q         <= pc_d;
      valid_q      <= valid_d;
    end
  end

endmodule
